bilbo_bist_session: RTL
=======================

// Module: bilbo_bist_session
// PURPOSE
//  Parametrised BILBO register (normal/scan/PRPG/MISR) with built-in BIST session controller.
//  A session seeds the register, compresses pin for a programmed cycle count, then compares
//  the signature against expect_sig. Sits between a logic-under-test and the test/scan controller.
// PARAMETERS
//  WIDTH  16        register/signature width, >=4
//  POLY   16'hB400  feedback tap mask; fb = ^(r & POLY) (default x^16+x^14+x^13+x^11+1)
//  CNT_W  16        width of session length counter
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  mode        in   2      0 normal load, 1 scan shift, 2 PRPG, 3 MISR (honoured only when idle)
//  pin         in   WIDTH  parallel data / MISR input
//  shift_in    in   1      scan input, enters bit 0
//  shift_out   out  1      scan output = r[WIDTH-1]
//  pout        out  WIDTH  register contents r
//  start       in   1      session start pulse, sampled in IDLE only
//  length      in   CNT_W  compression cycles, sampled with start
//  seed        in   WIDTH  initial register value, sampled with start
//  expect_sig  in   WIDTH  golden signature, sampled in CHECK
//  busy        out  1      high in RUN and CHECK
//  done        out  1      one-cycle pulse at end of session
//  pass        out  1      compare result of last session, held until next start or rst
// BEHAVIOUR
//  - Reset: r=0, pout=0, shift_out=0, busy=0, done=0, pass=0, state IDLE, counter 0.
//  - rst mid-session aborts: no done pulse, pass=0, IDLE next cycle.
//  - Register update per edge (IDLE state, by mode):
//    0: r<=pin (pout==pin one edge later); 1: r<={r[W-2:0],shift_in};
//    2: r<={r[W-2:0],fb}; 3: r<={r[W-2:0],fb}^pin. All arithmetic mod 2, width WIDTH.
//  - FSM IDLE/RUN/CHECK. IDLE+start: r<=seed, pass<=0, cnt<=length; next RUN, or CHECK if length==0.
//  - RUN: r MISR-updated (mode 3 rule) regardless of mode input; cnt decrements;
//    on the edge where cnt==1, go CHECK. RUN lasts exactly length cycles.
//  - CHECK (1 cycle): pass<=(r==expect_sig), done<=1, r held, go IDLE.
//  - done visible after edge length+2, counting the start-sampling edge as edge 1.
//  - start while busy ignored; start and rst together: rst wins.
//  - mode ignored while busy; r never changes in CHECK.
//  - length max 2^CNT_W-1; counter does not wrap.
// CONFIGURATION
//  BILBO_LOCKUP_GUARD_EN defined: in IDLE with mode 2 and r==0, next r=1 (escapes all-zero lockup).
//  Not defined: all-zero state in PRPG is held at 0. MISR/RUN unaffected either way.
// STRUCTURE
//  Package bilbo_pkg: mode enum (MODE_NORM, MODE_SCAN, MODE_PRPG, MODE_MISR), FSM state enum,
//  and a next_lfsr(r, POLY) function.
//  Sub-module bilbo_reg: register + mode mux + feedback. The top adds FSM, counter and compare.
// TESTING (WIDTH=16, POLY=16'hB400)
//  - mode 0, pin=16'hA5C3 -> pout=16'hA5C3 after 1 edge. Then mode 1, shift_in=1 -> pout=16'h4B87, shift_out=0.
//  - mode 0 load 16'h0001, then mode 2 for 11 edges -> pout=16'h0801 (1<<k for k<=10, then fb=1).
//  - seed=0, length=1, pin=16'h1234, expect_sig=16'h1234, start -> busy 2 cycles,
//    done pulse after edge 3, pass=1. Repeat with expect_sig=16'h1235 -> pass=0.
//  - length=0, seed=16'hBEEF, expect_sig=16'hBEEF -> done after edge 2, pass=1, pout=16'hBEEF.
//  - length=100; assert rst at RUN cycle 50 -> no done, busy=0, pout=0, pass=0. start during RUN is ignored.
//  - mode 2 from r=0: without macro pout stays 0 for 20 edges; with BILBO_LOCKUP_GUARD_EN pout=16'h0001 after 1 edge.

Source files
------------

// File: rtl/bilbo_pkg.sv
// Shared types for the BILBO register and its BIST session controller.
// Holds the mode encoding, the controller state codes and the LFSR step function.
package bilbo_pkg;

    typedef enum logic [1:0] {
        MODE_NORM = 2'd0,
        MODE_SCAN = 2'd1,
        MODE_PRPG = 2'd2,
        MODE_MISR = 2'd3
    } mode_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_CHECK = 2'd2;

    // Widest register the step function supports; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] next_lfsr(input logic [MAX_W-1:0] r,
                                                   input logic [MAX_W-1:0] poly);
        return {r[MAX_W-2:0], ^(r & poly)};
    endfunction

endpackage

// File: rtl/bilbo_bist_session_if.sv
// Test/scan-controller side bus of the BILBO session block.
// master = controller driving mode/data/session requests, slave = the BILBO block.
interface bilbo_bist_session_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic [1:0]       mode;
    logic [WIDTH-1:0] pin;
    logic             shift_in;
    logic             shift_out;
    logic [WIDTH-1:0] pout;
    logic             start;
    logic [CNT_W-1:0] length;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] expect_sig;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output mode, pin, shift_in, start, length, seed, expect_sig,
        input  shift_out, pout, busy, done, pass
    );

    modport slave (
        input  mode, pin, shift_in, start, length, seed, expect_sig,
        output shift_out, pout, busy, done, pass
    );
endinterface

// File: rtl/bilbo_reg.sv
// BILBO register: parallel load, scan shift, PRPG and MISR with seed load and hold.
// BILBO_LOCKUP_GUARD_EN: PRPG steps out of the all-zero state instead of sticking there.
module bilbo_reg
    import bilbo_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 'hB400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             hold,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             shift_in,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] r_next;

    assign lfsr_step = WIDTH'(next_lfsr(MAX_W'(r), MAX_W'(POLY)));

    always_comb begin
        r_next = r;
        case (mode)
            MODE_NORM: r_next = pin;
            MODE_SCAN: r_next = {r[WIDTH-2:0], shift_in};
            MODE_PRPG: begin
`ifdef BILBO_LOCKUP_GUARD_EN
                if (r == '0)
                    r_next = WIDTH'(1);
                else
                    r_next = lfsr_step;
`else
                r_next = lfsr_step;
`endif
            end
            MODE_MISR: r_next = lfsr_step ^ pin;
            default:   r_next = r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r <= '0;
        else if (load)
            r <= seed;
        else if (!hold)
            r <= r_next;
    end

endmodule

// File: rtl/bilbo_bist_session.sv
// BILBO register plus BIST session controller: seed, compress pin for length cycles, compare.
// done pulses length+2 edges after start; BILBO_LOCKUP_GUARD_EN selects PRPG zero-state escape.
module bilbo_bist_session
    import bilbo_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 'hB400,
    parameter int               CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bilbo_bist_session_if.slave  bus
);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r;
    logic             pass;
    logic             done;
    logic             busy;
    mode_e            reg_mode;

    assign busy = (st != ST_IDLE);

    // While a session runs the register is a MISR no matter what the controller asks for.
    always_comb begin
        reg_mode = mode_e'(bus.mode);
        if (busy)
            reg_mode = MODE_MISR;
    end

    bilbo_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_reg (
        .clk      (clk),
        .rst      (rst),
        .load     ((st == ST_IDLE) && bus.start),
        .seed     (bus.seed),
        .hold     (st == ST_CHECK),
        .mode     (reg_mode),
        .pin      (bus.pin),
        .shift_in (bus.shift_in),
        .r        (r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= ST_IDLE;
            cnt  <= '0;
            pass <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (bus.start) begin
                        pass <= 1'b0;
                        cnt  <= bus.length;
                        st   <= (bus.length == '0) ? ST_CHECK : ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        st <= ST_CHECK;
                end
                ST_CHECK: begin
                    pass <= (r == bus.expect_sig);
                    done <= 1'b1;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign bus.pout      = r;
    assign bus.shift_out = r[WIDTH-1];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;

endmodule
